// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//
// Drives 16 output pins from the SPI configuration registers. Each pin is
// held low, held high, or follows a shared 8-bit PWM waveform. The waveform
// comes from a clock prescaler feeding a free-running period counter, which
// is compared against the duty-cycle value.
//
// Optional build macro: PWM_DUTY_SHADOW_EN
//   defined   - the compare uses a shadow copy of the duty value that loads
//               only at the 255->0 wrap, so duty writes take effect at the
//               next period boundary
//   undefined - the compare uses pwm_duty_cycle directly
//
// Parameters
//   CLK_DIV : system clocks per counter tick (1..65535)
//   CNT_W   : period counter width, fixed at 8
//
// Ports
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   en_reg_out_7_0  in   output enable, pins 7..0
//   en_reg_out_15_8 in   output enable, pins 15..8
//   en_reg_pwm_7_0  in   PWM mode select, pins 7..0
//   en_reg_pwm_15_8 in   PWM mode select, pins 15..8
//   pwm_duty_cycle  in   duty value 0x00..0xFF
//   out             out  registered pin drive
//   period_start    out  one-clock pulse on the edge the counter wraps to 0

module pwm_peripheral #(
    parameter int CLK_DIV = 3000,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] PRESCALE_LAST = 16'(CLK_DIV - 1);

    logic [15:0]      r_prescaler;
    logic [CNT_W-1:0] r_counter;
    logic [15:0]      r_out;
    logic             r_period_start;

    logic             w_tick;
    logic             w_wrap;
    logic [CNT_W-1:0] w_duty;
    logic             w_pwm_high;
    logic [15:0]      w_en_out;
    logic [15:0]      w_en_pwm;
    logic [15:0]      w_out_next;

    assign w_tick   = (r_prescaler == PRESCALE_LAST);
    assign w_wrap   = w_tick && (r_counter == {CNT_W{1'b1}});
    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Prescaler: counts 0..CLK_DIV-1; with CLK_DIV=1 it stays at 0 and
    // w_tick is asserted on every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + 16'd1;
        end
    end

    // Period counter advances once per tick and wraps naturally 255->0,
    // giving a period of exactly 256*CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter <= '0;
        end else if (w_tick) begin
            r_counter <= r_counter + 1'b1;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [CNT_W-1:0] r_duty_shadow;

    // Shadow duty loads only at the wrap so each period is generated from a
    // single duty value (no runt or stretched pulses on a mid-period write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= '0;
        end else if (w_wrap) begin
            r_duty_shadow <= pwm_duty_cycle;
        end
    end

    assign w_duty = r_duty_shadow;
`else
    assign w_duty = pwm_duty_cycle;
`endif

    // Full-scale duty is forced high so there is no one-tick low gap at 255.
    assign w_pwm_high = (w_duty == {CNT_W{1'b1}}) || (r_counter < w_duty);

    // Pin select: disabled pins low, enabled static pins high, PWM pins
    // follow the shared waveform.
    always_comb begin
        w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_high}});
    end

    // Output and period_start are flops so pin changes are glitch-free and
    // land exactly one clock after the inputs or counter that caused them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= w_out_next;
            r_period_start <= w_wrap;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers written over SPI and drives 16 output pins.
- Each pin is forced low, forced high, or driven by a shared 8-bit PWM waveform.
- The waveform comes from a clock prescaler and a free-running 8-bit period counter compared against the duty-cycle register.
- Sits directly downstream of the SPI register file; its outputs go to the chip output/bidirectional pads.

Parameters:
- CLK_DIV, 3000: system clocks per PWM counter tick; legal range 1..65535. At 10 MHz this gives ~13 Hz PWM (256 ticks/period).
- CNT_W, 8: width of the period counter. Fixed at 8; the parameter exists only for readability.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM mode select, pins 15..8
- pwm_duty_cycle  input  8  duty value, 0x00..0xFF
- out  output  16  registered pin drive; out[15:8] maps to the *_15_8 registers
- period_start  output  1  one-clk pulse on the clock where the counter wraps 255->0

Behaviour:
- Reset is asynchronous, active-low, on clk / rst_n. While asserted:
  - prescaler = 0, counter = 0, out = 16'h0000, period_start = 0, duty shadow = 0x00.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick asserts on the clk where prescaler == CLK_DIV-1.
  - CLK_DIV=1 means tick on every clock.
- Period counter:
  - Increments on tick only; wraps 255->0, so the period is exactly 256*CLK_DIV clocks.
  - period_start is registered and high for one clk on the same edge the counter becomes 0 from 255.
- Waveform: pwm_high = (duty == 8'hFF) | (counter < duty).
  - duty 0x00: never high.
  - duty 0xFF: constantly high, no 1-tick gap.
  - duty N (1..254): high for N ticks at the start of each period.
- Per pin i, evaluated combinationally and then registered:
  - en_out[i]=0: out[i]=0.
  - en_out[i]=1, en_pwm[i]=0: out[i]=1.
  - en_out[i]=1, en_pwm[i]=1: out[i]=pwm_high.
- Latency:
  - Enable/mode register changes appear on out exactly 1 clk later.
  - The counter-to-out path is 1 clk, so the first PWM high after wrap appears on the clk after counter==0 is loaded.
- Configuration changes mid-period do not reset the prescaler or counter; the waveform stays phase-continuous.
- Enable edges cause no glitches: out is a flop per bit.
- Reset mid-period: everything returns to reset values immediately (asynchronous). After release the counter restarts from 0, and the first tick is CLK_DIV clocks after release.
- The input registers are treated as quasi-static and are sampled every clk. No handshake is required, because the SPI block updates them synchronously in the same clk domain.

Optional Feature:
- Macro: PWM_DUTY_SHADOW_EN.
- Defined:
  - The compare uses a shadow copy of pwm_duty_cycle.
  - The shadow loads only on the clk the counter wraps 255->0 (same edge as period_start), so a duty write takes effect at the next period boundary.
  - No runt or extended pulses occur.
  - Shadow resets to 0x00; the first valid duty is applied at the first wrap after reset.
- Undefined:
  - No shadow register; the compare uses pwm_duty_cycle directly.
  - A duty write takes effect on the next clk (1 clk to out).

Test Plan (CLK_DIV=4, i.e. 1024 clk period):
- Reset: hold rst_n=0 with all registers 0xFF -> out=16'h0000 and period_start=0 throughout; after release, first period_start occurs 1024 clks later.
- Static drive: en_out=16'hA5C3, en_pwm=0 -> out=16'hA5C3 one clk after the write; set en_out=0 -> out=0 next clk.
- 50% duty: en_out=en_pwm=16'hFFFF, duty=0x80 -> each pin high 512 clks, low 512 clks per period, rising edge 1 clk after period_start.
- Extremes: duty=0x00 -> PWM pins constantly 0; duty=0xFF -> constantly 1 across ≥3 periods, no low clk at wrap.
- Mixed mode: en_out=16'h00FF, en_pwm=16'h000F, duty=0x40 -> pins 3..0 high 256/1024 clks; pins 7..4 steady 1; pins 15..8 steady 0.
- Mid-period duty change from 0x40 to 0xC0 at counter=0x80:
  - With PWM_DUTY_SHADOW_EN: the current period ends as a 0x40 waveform, and the next period is high 768 clks.
  - Without it: the pin goes high 1 clk after the write and stays high until counter=0xC0.
